// File: rtl/mul_alu_sequencer.sv
// mul_alu_sequencer: runs 32-bit MUL as shift-and-add on the shared EX ALU.
// Ports:
//   clk, rst (sync, active-high)
//   mulStart, mulOpA, mulOpB          : multiply request from EX
//   pipeExecuteCommand, pipeIn1/2     : pipeline's own ALU request
//   aluResult                         : ALU output fed back
//   aluCommand, aluIn1/2              : muxed ALU request
//   stall, flagWriteBlock, busy       : pipeline control while multiplying
//   mulDone, mulResult                : product-valid pulse and product
// Build option: define MUL_EARLY_EXIT_EN to stop once the multiplier runs out
// of set bits (zero multiplier completes without entering RUN).
module mul_alu_sequencer #(
    parameter logic [3:0] ADD_CMD  = 4'b0010,
    parameter int         ITER_MAX = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mulStart,
    input  logic [31:0] mulOpA,
    input  logic [31:0] mulOpB,
    input  logic [3:0]  pipeExecuteCommand,
    input  logic [31:0] pipeIn1,
    input  logic [31:0] pipeIn2,
    input  logic [31:0] aluResult,
    output logic [3:0]  aluCommand,
    output logic [31:0] aluIn1,
    output logic [31:0] aluIn2,
    output logic        stall,
    output logic        flagWriteBlock,
    output logic        busy,
    output logic        mulDone,
    output logic [31:0] mulResult
);

    localparam int CW = $clog2(ITER_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   acc;
    logic [31:0]   res;
    logic [CW-1:0] cnt;
    logic          last_iter;
    logic          skip_run;

`ifdef MUL_EARLY_EXIT_EN
    // Stop as soon as the shifted multiplier has no set bits left.
    assign last_iter = (b[31:1] == 31'd0) ||
                       (cnt == CW'(ITER_MAX - 1));
    assign skip_run  = (mulOpB == 32'd0);
`else
    assign last_iter = (cnt == CW'(ITER_MAX - 1));
    assign skip_run  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= nxt;
            unique case (state)
                IDLE: begin
                    if (mulStart) begin
                        a   <= mulOpA;
                        b   <= mulOpB;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    // ALU is computing acc + a this cycle.
                    if (b[0]) begin
                        acc <= aluResult;
                    end
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    res <= acc;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        nxt        = state;
        aluCommand = pipeExecuteCommand;
        aluIn1     = pipeIn1;
        aluIn2     = pipeIn2;
        stall      = 1'b0;
        busy       = 1'b0;
        mulDone    = 1'b0;
        mulResult  = res;
        unique case (state)
            IDLE: begin
                stall = mulStart;
                if (mulStart) begin
                    nxt = skip_run ? DONE : RUN;
                end
            end
            RUN: begin
                aluCommand = ADD_CMD;
                aluIn1     = acc;
                aluIn2     = a;
                stall      = 1'b1;
                busy       = 1'b1;
                if (last_iter) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                // Stall drops here so the MUL leaves EX with the product.
                mulDone   = 1'b1;
                mulResult = acc;
                nxt       = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    assign flagWriteBlock = busy;

endmodule

// File: doc/mul_alu_sequencer.md
# mul_alu_sequencer

Multi-cycle controller that runs 32-bit MUL instructions on the single ALU of the execution stage. It uses shift-and-add and issues ADD commands to the ALU itself. While a multiply is in progress it takes ALU ownership from the pipeline, stalls the front end and blocks status-flag writes. When the multiply finishes it hands back a 32-bit product and returns the ALU to the pipeline.

## Interface
Parameters:
- ADD_CMD, 4'b0010, ALU execute-command encoding for ADD
- ITER_MAX, 32, iteration bound (multiplier width)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- mulStart  input  1  one-cycle request from the EX stage when a MUL occupies EX
- mulOpA  input  32  multiplicand (Rm value)
- mulOpB  input  32  multiplier (Rs value)
- pipeExecuteCommand  input  4  pipeline's ALU command
- pipeIn1, pipeIn2  input  32  pipeline's ALU operands
- aluResult  input  32  ALU `out`, fed back
- aluCommand  output  4  command driven to the ALU
- aluIn1, aluIn2  output  32  operands driven to the ALU
- stall  output  1  freeze the IF/ID/EX pipeline registers
- flagWriteBlock  output  1  inhibit status-register update
- busy  output  1  sequencer owns the ALU
- mulDone  output  1  one-cycle product-valid pulse
- mulResult  output  32  low 32 bits of mulOpA*mulOpB

## Operation
States:
- **IDLE**
  - ALU mux passes `pipe*` through.
  - On mulStart: latch A<=mulOpA, B<=mulOpB, acc<=0, cnt<=0, then go to RUN.
- **RUN**
  - Drives aluCommand=ADD_CMD, aluIn1=acc, aluIn2=A.
  - Each cycle: if B[0], acc<=aluResult. Then A<=A<<1 (overflow discarded), B<=B>>1, cnt<=cnt+1.
  - Leaves for DONE after the iteration where cnt==ITER_MAX-1 (exit rule under Configuration).
- **DONE**
  - Exactly one cycle: mulDone=1, mulResult=acc.
  - ALU mux returns to `pipe*`. Always goes to IDLE next.

Outputs:
- stall = mulStart in IDLE (combinational) OR state==RUN. It is low in DONE, so the MUL leaves EX carrying mulResult.
- flagWriteBlock = busy = (state==RUN).
- mulResult holds its last product until the next DONE.

Arithmetic:
- Unsigned shift-add. The low 32 bits are the same for signed operands (ARM MUL semantics).
- No flags are produced.

Boundary conditions:
- mulStart in RUN or DONE: ignored; no relatch.
- Reset at any point:
  - Next state IDLE; acc, A, B, cnt, mulResult cleared.
  - stall, busy and mulDone low. The in-flight product is discarded.
- aluResult is used only in RUN; ALU flags from RUN cycles never reach the status register.

## Timing
- Reset values: aluCommand/aluIn1/aluIn2 follow `pipe*`; stall=0, flagWriteBlock=0, busy=0, mulDone=0, mulResult=0.
- mulStart sampled at edge k:
  - RUN occupies cycles k+1..k+N.
  - DONE is cycle k+N+1.
  - Without early exit, N=32, so mulDone appears 33 cycles after the start edge.
- stall is high from the mulStart cycle through the last RUN cycle: N+1 cycles total.
- ALU operand and command outputs are combinational from state and registers. The acc update closes through the ALU within one cycle.

## Configuration
- Macro: `MUL_EARLY_EXIT_EN`.
- Defined:
  - RUN exits to DONE after any iteration in which the post-shift B is zero.
  - If mulOpB==0 at start, IDLE goes straight to DONE: result 0, stall high only in the start cycle.
  - N = index of the highest set bit of mulOpB, plus 1.
- Undefined:
  - N=32 always; latency is fixed regardless of operands.

## Test plan
- Passthrough: IDLE, pipeExecuteCommand=4'b0100, pipeIn1=9, pipeIn2=4 -> ALU outputs mirror the inputs; stall=0, busy=0.
- 6×7: mulStart with A=6, B=7 -> mulResult=42 with a one-cycle mulDone.
  - Macro off: DONE at k+33.
  - Macro on: DONE at k+4.
  - stall high for every cycle up to DONE, low in DONE.
- 0xFFFFFFFF×0xFFFFFFFF -> mulResult=0x00000001 at k+33 (either config); flagWriteBlock high in all 32 RUN cycles.
- Zero multiplier: A=0x1234, B=0.
  - Macro on: DONE at k+1, result 0.
  - Macro off: DONE at k+33, result 0.
- Reset mid-op: start A=3, B=5, assert rst in the 2nd RUN cycle -> next cycle IDLE, stall=0, mulResult=0, no mulDone; a later start with 2×8 returns 16.
- Start during RUN: second mulStart with A=100, B=100 while running 6×7 -> ignored; result 42; no second mulDone.
